// File: rtl/enc_pkg.sv
// Code map and FSM encoding shared by the one-hot decoder and the priority encoder,
// so the two blocks cannot disagree on which code selects which line.
package enc_pkg;

    localparam logic [1:0] CODE_B3 = 2'b00;
    localparam logic [1:0] CODE_B2 = 2'b01;
    localparam logic [1:0] CODE_B1 = 2'b10;
    localparam logic [1:0] CODE_B0 = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/prio_enc4_2.sv
// Combinational 4-to-2 priority encoder, bit 3 highest; also reports any/multi-hot.
module prio_enc4_2
    import enc_pkg::*;
(
    input  logic [3:0] y,
    output logic [1:0] w,
    output logic       any,
    output logic       multi
);

    always_comb begin
        w = CODE_B3;
        if (y[3])      w = CODE_B3;
        else if (y[2]) w = CODE_B2;
        else if (y[1]) w = CODE_B1;
        else if (y[0]) w = CODE_B0;
    end

    assign any = |y;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi = (y & (y - 4'd1)) != 4'd0;

endmodule

// File: rtl/encoder4_2_seq.sv
// Registered 4-to-2 priority encoder behind a valid/ready handshake with a
// one-entry output register and a saturating multi-hot counter.
module encoder4_2_seq
    import enc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       y_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       w_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             multi_err,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // Input side accepts whenever the output register is empty or being drained
    // this cycle; in_ready never depends on in_valid.

    state_e             state_q, state_d;
    logic [1:0]         w_q, w_d;
    logic               multi_q, multi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         enc_w;
    logic               enc_any;
    logic               enc_multi;
    logic               accept;

    prio_enc4_2 u_prio (
        .y     (y_in),
        .w     (enc_w),
        .any   (enc_any),
        .multi (enc_multi)
    );

    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        multi_d = multi_q;
        cnt_d   = cnt_q;
        if (accept && enc_any) begin
            state_d = ST_FULL;
            w_d     = enc_w;
            multi_d = enc_multi;
            if (enc_multi && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end else if ((state_q == ST_FULL) && out_ready) begin
            // Drained with nothing (or an all-zero vector) behind it; w_out keeps its value.
            state_d = ST_EMPTY;
            multi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            w_q     <= CODE_B3;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign w_out     = w_q;
    assign multi_err = multi_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Directed + random bench for encoder4_2_seq: scoreboard queue of expected
// {multi_err, w_out}, checked with immediate assertions.
module tb_encoder4_2_seq;

    logic       clk;
    logic       rst;
    logic [3:0] y_in;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, multi_err_a;
    logic [1:0] w_out_a;
    logic [7:0] err_count_a;

    logic       in_ready_b, out_valid_b, multi_err_b;
    logic [1:0] w_out_b;
    logic [1:0] err_count_b;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];
    logic       m_full;
    int         m_cnt8;
    int         m_cnt2;

    encoder4_2_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .in_valid(in_valid),
        .in_ready(in_ready_a), .w_out(w_out_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .multi_err(multi_err_a), .err_count(err_count_a)
    );

    encoder4_2_seq #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .y_in(y_in), .in_valid(in_valid),
        .in_ready(in_ready_b), .w_out(w_out_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .multi_err(multi_err_b), .err_count(err_count_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ref_code(input logic [3:0] v);
        casez (v)
            4'b1???: return 2'b00;
            4'b01??: return 2'b01;
            4'b001?: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic ref_multi(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(v[i]);
        return n > 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_full = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    // driver: one clock cycle with the given inputs, checks before and after the edge
    task automatic cycle(input logic [3:0] y, input logic v, input logic r);
        logic acc;
        logic nxt;
        logic [2:0] e;
        y_in = y; in_valid = v; out_ready = r;
        @(negedge clk);
        chk("in_ready", {7'd0, in_ready_a}, {7'd0, (!m_full || r)});
        chk("out_valid", {7'd0, out_valid_a}, {7'd0, m_full});
        chk("sat_out_valid", {7'd0, out_valid_b}, {7'd0, m_full});
        if (m_full) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty_while_full", 8'd1, 8'd0);
            end else begin
                e = exp_q[0];
                chk("w_out", {6'd0, w_out_a}, {6'd0, e[1:0]});
                chk("multi_err", {7'd0, multi_err_a}, {7'd0, e[2]});
                chk("sat_w_out", {6'd0, w_out_b}, {6'd0, e[1:0]});
                if (r) void'(exp_q.pop_front());
            end
        end else begin
            chk("multi_err_empty", {7'd0, multi_err_a}, 8'd0);
        end
        acc = v && (!m_full || r);
        nxt = m_full && !r;
        if (acc && y != 4'd0) begin
            exp_q.push_back({ref_multi(y), ref_code(y)});
            nxt = 1'b1;
            if (ref_multi(y)) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        m_full = nxt;
        @(posedge clk);
        #1;
        chk("err_count", err_count_a, m_cnt8[7:0]);
        chk("sat_err_count", {6'd0, err_count_b}, m_cnt2[7:0]);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {7'd0, out_valid_a}, 8'd0);
        chk("rst_w_out", {6'd0, w_out_a}, 8'd0);
        chk("rst_err_count", err_count_a, 8'd0);
        chk("rst_multi_err", {7'd0, multi_err_a}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready_a}, 8'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {7'd0, in_ready_a}, 8'd1);
    endtask

    initial begin
        rst = 1'b1; y_in = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // reset mid-operation
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        apply_reset();

        // one-hot sweep, back-to-back
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0010, 1'b1, 1'b1);
        cycle(4'b0001, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);

        // priority / multi-hot
        cycle(4'b0110, 1'b1, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        chk("multi_count_two", err_count_a, 8'd2);

        // backpressure with a waiting input
        cycle(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b1);
        chk("bp_w_after_handoff", {6'd0, w_out_a}, 8'h03);
        cycle(4'b0000, 1'b0, 1'b1);

        // zero vector in EMPTY and in FULL
        cycle(4'b0000, 1'b1, 1'b1);
        chk("zero_empty_stays", {7'd0, out_valid_a}, 8'd0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b1);
        chk("zero_full_drains", {7'd0, out_valid_a}, 8'd0);

        // saturation on the 2-bit counter
        apply_reset();
        cycle(4'b1100, 1'b1, 1'b1); chk("sat1", {6'd0, err_count_b}, 8'd1);
        cycle(4'b0011, 1'b1, 1'b1); chk("sat2", {6'd0, err_count_b}, 8'd2);
        cycle(4'b1010, 1'b1, 1'b1); chk("sat3", {6'd0, err_count_b}, 8'd3);
        cycle(4'b0101, 1'b1, 1'b1); chk("sat4", {6'd0, err_count_b}, 8'd3);
        cycle(4'b1111, 1'b1, 1'b1); chk("sat5", {6'd0, err_count_b}, 8'd3);
        chk("wide_count5", err_count_a, 8'd5);
        cycle(4'b0000, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 60; i++)
            cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 2; i++) cycle(4'b0000, 1'b0, 1'b1);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/encoder4_2_seq.md
Name: encoder4_2_seq

Overview:
- Registered 4-to-2 priority encoder. It is the inverse of the team's one-hot 2-to-4 decoder and uses the same code map: 1000->00, 0100->01, 0010->10, 0001->11.
- Takes a 4-bit request/one-hot vector over a valid/ready handshake and returns the 2-bit code through a one-entry output register.
- Flags multi-hot inputs and counts them.
- Sits between a one-hot source (decoder output, keypad or button lines) and a downstream consumer that can apply backpressure.

Parameters:
- CNT_W, 8, width of the saturating multi-hot error counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- y_in  in  4  request vector; bit 3 has highest priority.
- in_valid  in  1  y_in is presented.
- in_ready  out  1  block can accept y_in this cycle.
- w_out  out  2  encoded index.
- out_valid  out  1  w_out/multi_err hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- multi_err  out  1  current result came from a vector with more than one bit set.
- err_count  out  CNT_W  saturating count of accepted multi-hot vectors.

Behaviour:
- Reset:
  - The only clock and reset are clk and rst; rst is asynchronous, active-high.
  - While rst is high: w_out=00, out_valid=0, multi_err=0, err_count=0, FSM=EMPTY.
  - in_ready is combinational, so it is 1 during reset. in_valid is ignored during reset.
  - rst asserted mid-operation discards any pending result immediately; no partial output appears after release.
- FSM (2 states):
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - out_valid is the registered state bit.
- in_ready = !out_valid || out_ready. This is combinational; there is no combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready.
- Encode (priority, bit 3 first):
  - y_in[3] -> 00.
  - else y_in[2] -> 01.
  - else y_in[1] -> 10.
  - else y_in[0] -> 11.
- Transitions:
  - EMPTY, accept, y_in!=0: load w_out and multi_err -> FULL. Latency is 1 cycle (result visible the cycle after accept).
  - EMPTY, accept, y_in==0: vector dropped, stay EMPTY, no counter change.
  - FULL, out_ready=0: hold w_out and multi_err stable; in_ready=0.
  - FULL, out_ready=1, no accept (in_valid=0): -> EMPTY.
  - FULL, out_ready=1, accept with y_in!=0: result handed off and new result loaded in the same edge; stay FULL. Sustained throughput is 1 per cycle.
  - FULL, out_ready=1, accept with y_in==0: -> EMPTY.
- multi_err = (popcount(y_in) > 1) at accept. It is only meaningful while out_valid=1 and is 0 when EMPTY.
- err_count:
  - Increments by 1 on each accepted multi-hot vector.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- w_out keeps its last value when returning to EMPTY. The consumer must qualify it with out_valid.
- No X propagation: all registers have a defined reset value and all case branches are covered.

Decomposition:
- Shared package (enc_pkg):
  - Code constants CODE_B3=2'b00, CODE_B2=2'b01, CODE_B1=2'b10, CODE_B0=2'b11.
  - FSM state encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
  - The package is shared with the decoder so the code map cannot diverge.
- One natural combinational sub-module: prio_enc4_2.
  - Inputs: y[3:0].
  - Outputs: w[1:0], any, multi.
  - Instantiated once; the top level holds only the handshake, register and counter.

Test Plan:
- Reset mid-operation: send 0100 with out_ready=0 (now FULL), assert rst -> out_valid=0, w_out=00, err_count=0 immediately; after release in_ready=1.
- One-hot sweep, out_ready=1: send 1000, 0100, 0010, 0001 back-to-back -> w_out=00, 01, 10, 11 on consecutive cycles, one cycle after each accept; out_valid=1 throughout; multi_err=0.
- Priority/multi-hot: send 0110 then 1111 -> w_out=01 with multi_err=1, then w_out=00 with multi_err=1; err_count=2.
- Backpressure: send 0010 with out_ready=0 for 5 cycles while in_valid=1 with 0001 -> in_ready=0, w_out=10 held stable; on out_ready=1 both the handoff and the load of 0001 occur in the same edge; next w_out=11.
- Zero input: send 0000 in EMPTY -> out_valid stays 0, err_count unchanged. Send 0000 while FULL with out_ready=1 -> out_valid=0 next cycle.
- Saturation (CNT_W=2): send 5 multi-hot vectors -> err_count goes 1, 2, 3, 3, 3.
